load_store_unit: RTL and testbench

//   Executes the memory access selected by the instruction decoder's mem_read/mem_write/mem_size/mem_unsigned.

---
 rtl/load_store_unit.sv | 242 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Executes one data-memory access at a time for the execute stage.
//            It drives a word-addressed memory port with byte enables and
//            lane-replicated store data. Load data is returned sign- or
//            zero-extended and tagged with the destination register.
// Ports    : clk, rst_n (async active-low)
//            req_*_i / req_ready_o       : request from execute
//            resp_*_o                    : one-cycle completion to writeback
//            dmem_*_o / dmem_*_i         : data-memory request/response
// Params   : TIMEOUT_CYCLES - number of REQ+WAIT cycles allowed before the
//            access completes with an error (0 disables the timeout)
// Config   : MISALIGN_TRAP_EN - when defined, misaligned half/word accesses
//            complete with an error and make no memory access
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_rd_addr_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // The counter only needs to reach TIMEOUT_CYCLES-1, at which point the
  // access is abandoned.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [4:0]         rd_q, rd_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               req_bad;
  logic               misalign;
  logic [3:0]         req_be;
  logic [31:0]        req_wlane;
  logic [31:0]        load_data;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;
  logic               timeout;

  // --------------------------------------------------------------------------
  // Request decode (evaluated on the incoming request while IDLE)
  // --------------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
  assign misalign = ((mem_size_i == 2'b01) && addr_i[0]) ||
                    ((mem_size_i == 2'b10) && (addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = ~(mem_read_i ^ mem_write_i) || (mem_size_i == 2'b11) || misalign;

  always_comb begin
    req_be    = 4'hF;
    req_wlane = wdata_i;
    case (mem_size_i)
      2'b00: begin
        req_be    = 4'b0001 << addr_i[1:0];
        req_wlane = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        // Half accesses use addr[1] only; addr[0] never shifts the mask.
        req_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        req_wlane = {2{wdata_i[15:0]}};
      end
      default: begin
        req_be    = 4'hF;
        req_wlane = wdata_i;
      end
    endcase
    // Loads present the mask only as information; no store data is driven.
    if (!mem_write_i) begin
      req_wlane = 32'h0;
    end
  end

  // --------------------------------------------------------------------------
  // Load lane extraction and extension
  // --------------------------------------------------------------------------
  assign load_byte = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign load_half = dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, load_byte}
                                 : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_data = uns_q ? {16'h0, load_half}
                                 : {{16{load_half[15]}}, load_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // --------------------------------------------------------------------------
  // FSM next state and capture registers
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = mem_write_i;
          size_d  = mem_size_i;
          uns_d   = mem_unsigned_i;
          addr_d  = addr_i;
          be_d    = req_be;
          wdata_d = req_wlane;
          rd_d    = rd_addr_i;
          err_d   = req_bad;
          rdata_d = 32'h0;
          cnt_d   = '0;
          state_d = req_bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A granted store is complete; a load granted on the final allowed
        // cycle has no time left to return data, so the timeout wins.
        if (dmem_gnt_i && we_q) begin
          state_d = S_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (dmem_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_rvalid_i) begin
          rdata_d = load_data;
          state_d = S_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registered state, memory fields only in REQ
  // --------------------------------------------------------------------------
  assign req_ready_o    = (state_q == S_IDLE);
  assign dmem_req_o     = (state_q == S_REQ);
  assign dmem_we_o      = (state_q == S_REQ) && we_q;
  assign dmem_addr_o    = (state_q == S_REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_be_o      = (state_q == S_REQ) ? be_q : 4'h0;
  assign dmem_wdata_o   = (state_q == S_REQ) ? wdata_q : 32'h0;

  assign resp_valid_o   = (state_q == S_DONE);
  assign resp_err_o     = (state_q == S_DONE) && err_q;
  assign resp_rdata_o   = (state_q == S_DONE) ? rdata_q : 32'h0;
  assign resp_rd_addr_o = ((state_q == S_DONE) && !err_q && !we_q) ? rd_q : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed, table-driven bench for load_store_unit plus sequences
//            for delayed grant, timeout, stray rvalid and mid-access reset.
//            A second instance with TIMEOUT_CYCLES=4 shares all inputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata, dmem_rdata;
  logic [4:0]  rd_addr;
  logic        dmem_gnt, dmem_rvalid;

  logic        req_ready, resp_valid, resp_err, dmem_req, dmem_we;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata;
  logic [4:0]  resp_rd_addr;
  logic [3:0]  dmem_be;

  logic        t_req_ready, t_resp_valid, t_resp_err, t_dmem_req, t_dmem_we;
  logic [31:0] t_resp_rdata, t_dmem_addr, t_dmem_wdata;
  logic [4:0]  t_resp_rd_addr;
  logic [3:0]  t_dmem_be;

  int n_total = 0;
  int n_pass  = 0;

  load_store_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_size_i(mem_size),
    .mem_unsigned_i(mem_unsigned), .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd_addr),
    .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
    .resp_rd_addr_o(resp_rd_addr),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(t_req_ready),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_size_i(mem_size),
    .mem_unsigned_i(mem_unsigned), .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd_addr),
    .resp_valid_o(t_resp_valid), .resp_err_o(t_resp_err), .resp_rdata_o(t_resp_rdata),
    .resp_rd_addr_o(t_resp_rd_addr),
    .dmem_req_o(t_dmem_req), .dmem_we_o(t_dmem_we), .dmem_addr_o(t_dmem_addr),
    .dmem_be_o(t_dmem_be), .dmem_wdata_o(t_dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rda;
    logic [31:0] mrdata;
    logic        acc;      // memory access expected
    logic [3:0]  be;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  rrd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rd wr sz uns addr wdata rda mrdata acc be daddr dwdata err rdata rrd
    vecs[0]  = '{1,0,2'b00,0,32'h103,32'h0,5'd5,32'h80FF_0000,1,4'b1000,32'h100,32'h0,0,32'hFFFF_FF80,5'd5};
    vecs[1]  = '{1,0,2'b01,1,32'h202,32'h0,5'd6,32'hBEEF_1234,1,4'b1100,32'h200,32'h0,0,32'h0000_BEEF,5'd6};
    vecs[2]  = '{1,0,2'b01,0,32'h202,32'h0,5'd7,32'hBEEF_1234,1,4'b1100,32'h200,32'h0,0,32'hFFFF_BEEF,5'd7};
    vecs[3]  = '{0,1,2'b00,0,32'h11,32'hAB,5'd9,32'h0,1,4'b0010,32'h10,32'hABAB_ABAB,0,32'h0,5'd0};
    vecs[4]  = '{0,1,2'b01,0,32'h22,32'h1234_CAFE,5'd9,32'h0,1,4'b1100,32'h20,32'hCAFE_CAFE,0,32'h0,5'd0};
    vecs[5]  = '{0,1,2'b10,0,32'h40,32'hDEAD_BEEF,5'd9,32'h0,1,4'b1111,32'h40,32'hDEAD_BEEF,0,32'h0,5'd0};
    vecs[6]  = '{1,0,2'b00,1,32'h101,32'h0,5'd10,32'h1234_A5C3,1,4'b0010,32'h100,32'h0,0,32'h0000_00A5,5'd10};
    vecs[7]  = '{1,0,2'b10,0,32'h80,32'h0,5'd11,32'h8765_4321,1,4'b1111,32'h80,32'h0,0,32'h8765_4321,5'd11};
    vecs[8]  = '{1,1,2'b10,0,32'h80,32'h5,5'd12,32'h0,0,4'h0,32'h0,32'h0,1,32'h0,5'd0};
    vecs[9]  = '{0,0,2'b10,0,32'h80,32'h5,5'd13,32'h0,0,4'h0,32'h0,32'h0,1,32'h0,5'd0};
    vecs[10] = '{1,0,2'b11,0,32'h80,32'h5,5'd14,32'h0,0,4'h0,32'h0,32'h0,1,32'h0,5'd0};
`ifdef MISALIGN_TRAP_EN
    vecs[11] = '{1,0,2'b10,0,32'h6,32'h0,5'd3,32'h1122_3344,0,4'h0,32'h0,32'h0,1,32'h0,5'd0};
    vecs[12] = '{1,0,2'b01,0,32'h3,32'h0,5'd8,32'h7FFF_0000,0,4'h0,32'h0,32'h0,1,32'h0,5'd0};
`else
    vecs[11] = '{1,0,2'b10,0,32'h6,32'h0,5'd3,32'h1122_3344,1,4'b1111,32'h4,32'h0,0,32'h1122_3344,5'd3};
    vecs[12] = '{1,0,2'b01,0,32'h3,32'h0,5'd8,32'h7FFF_0000,1,4'b1100,32'h0,32'h0,0,32'h0000_7FFF,5'd8};
`endif

    rst_n = 1'b0; req_valid = 0; mem_read = 0; mem_write = 0; mem_unsigned = 0;
    mem_size = 2'b00; addr = 0; wdata = 0; rd_addr = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    #12;
    chk("reset_outputs",
        {req_ready, resp_valid, resp_err, resp_rdata, resp_rd_addr, dmem_req, dmem_we, dmem_be},
        {1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'h0});
    chk("reset_dmem", {dmem_addr, dmem_wdata}, 64'h0);
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven single accesses ----------------
    for (int i = 0; i < 13; i++) begin
      mem_read = vecs[i].rd; mem_write = vecs[i].wr; mem_size = vecs[i].size;
      mem_unsigned = vecs[i].uns; addr = vecs[i].addr; wdata = vecs[i].wdata;
      rd_addr = vecs[i].rda; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk($sformatf("v%0d_ready_low", i), req_ready, 1'b0);
      if (vecs[i].acc) begin
        chk($sformatf("v%0d_dmem", i), {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata},
            {1'b1, vecs[i].wr, vecs[i].be, vecs[i].daddr, vecs[i].dwdata});
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        if (vecs[i].rd) begin
          chk($sformatf("v%0d_wait", i), {resp_valid, dmem_req}, 2'b00);
          dmem_rvalid = 1'b1; dmem_rdata = vecs[i].mrdata;
          tick();
          dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        end
      end else begin
        chk($sformatf("v%0d_no_access", i), dmem_req, 1'b0);
      end
      chk($sformatf("v%0d_resp", i), {resp_valid, resp_err, resp_rdata, resp_rd_addr},
          {1'b1, vecs[i].err, vecs[i].rdata, vecs[i].rrd});
      tick();
      chk($sformatf("v%0d_back_idle", i), {resp_valid, req_ready}, 2'b01);
    end

    // ---------------- SW with grant delayed 5 cycles ----------------
    mem_read = 0; mem_write = 1; mem_size = 2'b10; mem_unsigned = 0;
    addr = 32'h0000_0104; wdata = 32'h0BAD_F00D; rd_addr = 5'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("swdly_c%0d", c),
          {req_ready, resp_valid, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata},
          {1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_0104, 32'h0BAD_F00D});
      if (c == 5) dmem_gnt = 1'b1;
      tick();
    end
    dmem_gnt = 1'b0;
    chk("swdly_resp", {resp_valid, resp_err, resp_rdata, resp_rd_addr, dmem_req},
        {1'b1, 1'b0, 32'h0, 5'd0, 1'b0});
    tick();

    // ---------------- timeout (TIMEOUT_CYCLES=4 instance) ----------------
    mem_read = 1; mem_write = 0; mem_size = 2'b10; addr = 32'h100; rd_addr = 5'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to_req_c%0d", c), {t_dmem_req, t_resp_valid, t_req_ready}, 3'b100);
      tick();
    end
    chk("to_resp", {t_resp_valid, t_resp_err, t_resp_rdata, t_resp_rd_addr, t_dmem_req},
        {1'b1, 1'b1, 32'h0, 5'd0, 1'b0});
    chk("to_main_still_req", dmem_req, 1'b1);
    tick();
    chk("to_idle", {t_resp_valid, t_req_ready}, 2'b01);
    // Stray read data after the timeout must not produce a response.
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_rvalid = 1'b0;
    chk("stray_rvalid", {t_resp_valid, t_req_ready, resp_valid}, 3'b010);

    // ---------------- reset mid-access on the main instance ----------------
    rst_n = 1'b0;
    #1;
    chk("rst_drop_req", {dmem_req, resp_valid, req_ready}, 3'b001);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst_hold_c%0d", c), {dmem_req, resp_valid}, 2'b00);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst_after_c%0d", c), {resp_valid, req_ready, dmem_req}, 3'b010);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
